// File: rtl/stack_cmd_sequencer_if.sv
// Request/response and stack-side bus of the stack command sequencer.
// The sequencer connects through the slave modport; the requester/stack side uses master.
interface stack_cmd_sequencer_if #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned DEPTH_W = 3
);
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [DATA_W-1:0]  req_data;
    logic [IDX_W-1:0]   req_index;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_err;
    logic [1:0]         command;
    logic [IDX_W-1:0]   index;
    logic [DATA_W-1:0]  stk_dout;
    logic               stk_doe;
    logic [DATA_W-1:0]  stk_din;
    logic [DEPTH_W-1:0] depth;
    logic               full;
    logic               empty;

    modport master (
        output req_valid, req_op, req_data, req_index, stk_din,
        input  req_ready, rsp_valid, rsp_data, rsp_err, command, index,
               stk_dout, stk_doe, depth, full, empty
    );

    modport slave (
        input  req_valid, req_op, req_data, req_index, stk_din,
        output req_ready, rsp_valid, rsp_data, rsp_err, command, index,
               stk_dout, stk_doe, depth, full, empty
    );
endinterface

// File: rtl/stack_cmd_sequencer.sv
// Upstream sequencer for the 5x4 structural stack: one COMMAND cycle per request, one-cycle response.
// Optional request guard (reject overflow/underflow/out-of-range GET) enabled by STACK_SEQ_GUARD_EN.
module stack_cmd_sequencer (
    input  logic                  clk,
    input  logic                  reset,
    stack_cmd_sequencer_if.slave  bus
);
    localparam int unsigned DEPTH_MAX = 5;
    localparam int unsigned DATA_W    = 4;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned DEPTH_W   = 3;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_GET  = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]         state_q,    state_d;
    logic [1:0]         op_q,       op_d;
    logic               ready_q,    ready_d;
    logic [1:0]         command_q,  command_d;
    logic [IDX_W-1:0]   index_q,    index_d;
    logic [DATA_W-1:0]  stk_dout_q, stk_dout_d;
    logic               stk_doe_q,  stk_doe_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q,  rsp_err_d;
    logic [DEPTH_W-1:0] depth_q,    depth_d;
    logic               full_q;
    logic               empty_q;
    logic               reject_c;

`ifdef STACK_SEQ_GUARD_EN
    assign reject_c = ((bus.req_op == OP_PUSH) && full_q)
                   || ((bus.req_op == OP_POP) && empty_q)
                   || ((bus.req_op == OP_GET) && (bus.req_index >= IDX_W'(depth_q)));
`else
    assign reject_c = 1'b0;
`endif

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ready_d     = 1'b0;
        command_d   = OP_NOP;
        index_d     = '0;
        stk_dout_d  = '0;
        stk_doe_d   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        depth_d     = depth_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    op_d = bus.req_op;
                    if (reject_c) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = S_ISSUE;
                        command_d = bus.req_op;
                        index_d   = bus.req_index;
                        if (bus.req_op == OP_PUSH) begin
                            stk_doe_d  = 1'b1;
                            stk_dout_d = bus.req_data;
                        end
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                if ((op_q == OP_POP) || (op_q == OP_GET)) begin
                    rsp_data_d = bus.stk_din;
                end
                // Depth saturates; the stack itself wraps on push-at-full
                if ((op_q == OP_PUSH) && (depth_q != DEPTH_W'(DEPTH_MAX))) begin
                    depth_d = depth_q + DEPTH_W'(1);
                end else if ((op_q == OP_POP) && (depth_q != '0)) begin
                    depth_d = depth_q - DEPTH_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            ready_q     <= 1'b1;
            command_q   <= OP_NOP;
            index_q     <= '0;
            stk_dout_q  <= '0;
            stk_doe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            depth_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ready_q     <= ready_d;
            command_q   <= command_d;
            index_q     <= index_d;
            stk_dout_q  <= stk_dout_d;
            stk_doe_q   <= stk_doe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            depth_q     <= depth_d;
            full_q      <= (depth_d == DEPTH_W'(DEPTH_MAX));
            empty_q     <= (depth_d == '0);
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.command   = command_q;
    assign bus.index     = index_q;
    assign bus.stk_dout  = stk_dout_q;
    assign bus.stk_doe   = stk_doe_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.depth     = depth_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Bench for stack_cmd_sequencer: behavioural 5-entry wrapping stack on the shared data bus,
// table-driven requests with a response scoreboard, plus handshake and reset-in-flight sequences.
module tb_stack_cmd_sequencer;
    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] GET  = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [2:0] idx;
        logic [3:0] exp_data;
        logic       exp_err;
        logic [2:0] exp_depth;
        logic       chk_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    vec_t sb[$];

    stack_cmd_sequencer_if bus ();

    stack_cmd_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural stack: circular, top at sp-1, push at full overwrites the oldest entry
    logic [3:0] mem [5];
    int         sp;
    logic [3:0] stack_rd;

    always_comb begin
        int p;
        p = (bus.command == POP) ? 0 : (int'(bus.index) % 5);
        p = (sp + 4 - p) % 5;
        stack_rd = mem[p];
    end

    assign bus.stk_din = bus.stk_doe ? bus.stk_dout
                       : ((bus.command == POP) || (bus.command == GET)) ? stack_rd : 4'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= 0;
        end else if (bus.command == PUSH) begin
            mem[sp] <= bus.stk_din;
            sp      <= (sp + 1) % 5;
        end else if (bus.command == POP) begin
            sp <= (sp + 4) % 5;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response scoreboard and per-cycle bus protocol checks
    logic [1:0] prev_cmd = 2'b00;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    if (e.chk_data) chk("rsp_data", int'(bus.rsp_data), int'(e.exp_data));
                    chk("rsp_err", int'(bus.rsp_err), int'(e.exp_err));
                    chk("depth", int'(bus.depth), int'(e.exp_depth));
                    chk("full", int'(bus.full), int'(e.exp_depth == 3'd5));
                    chk("empty", int'(bus.empty), int'(e.exp_depth == 3'd0));
                end
            end
            if (bus.command != NOP) chk("cmd_single_cycle", int'(prev_cmd), 0);
            if (bus.stk_doe || bus.command == PUSH)
                chk("doe_only_push_issue", int'(bus.stk_doe), int'(bus.command == PUSH));
        end
        prev_cmd = bus.command;
    end

    task automatic wait_sb_empty();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        int lat;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_data  = v.data;
        bus.req_index = v.idx;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("command", int'(bus.command), v.exp_err ? 0 : int'(v.op));
        chk("stk_doe", int'(bus.stk_doe), int'((v.op == PUSH) && !v.exp_err));
        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, v.exp_err ? 1 : 2);
        wait_sb_empty();
    endtask

    initial begin
        int acc[$];
        vec_t v;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[$];
        vec_t v;

        tbl.push_back('{PUSH, 4'h5, 3'd0, 4'h0, 1'b0, 3'd1, 1'b1});
        tbl.push_back('{PUSH, 4'hA, 3'd0, 4'h0, 1'b0, 3'd2, 1'b1});
        tbl.push_back('{PUSH, 4'h3, 3'd0, 4'h0, 1'b0, 3'd3, 1'b1});
        tbl.push_back('{POP,  4'h0, 3'd0, 4'h3, 1'b0, 3'd2, 1'b1});
        tbl.push_back('{GET,  4'h0, 3'd0, 4'hA, 1'b0, 3'd2, 1'b1});
        tbl.push_back('{GET,  4'h0, 3'd1, 4'h5, 1'b0, 3'd2, 1'b1});
        tbl.push_back('{NOP,  4'hF, 3'd0, 4'h0, 1'b0, 3'd2, 1'b1});
`ifdef STACK_SEQ_GUARD_EN
        tbl.push_back('{GET,  4'h0, 3'd2, 4'h0, 1'b1, 3'd2, 1'b1});
`endif
        tbl.push_back('{POP,  4'h0, 3'd0, 4'hA, 1'b0, 3'd1, 1'b1});
        tbl.push_back('{POP,  4'h0, 3'd0, 4'h5, 1'b0, 3'd0, 1'b1});
`ifdef STACK_SEQ_GUARD_EN
        tbl.push_back('{POP,  4'h0, 3'd0, 4'h0, 1'b1, 3'd0, 1'b1});
`else
        tbl.push_back('{POP,  4'h0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0});
`endif
        for (int i = 1; i <= 5; i++)
            tbl.push_back('{PUSH, 4'(i), 3'd0, 4'h0, 1'b0, 3'(i), 1'b1});
`ifdef STACK_SEQ_GUARD_EN
        tbl.push_back('{PUSH, 4'h6, 3'd0, 4'h0, 1'b1, 3'd5, 1'b1});
        tbl.push_back('{POP,  4'h0, 3'd0, 4'h5, 1'b0, 3'd4, 1'b1});
`else
        tbl.push_back('{PUSH, 4'h6, 3'd0, 4'h0, 1'b0, 3'd5, 1'b1});
        tbl.push_back('{POP,  4'h0, 3'd0, 4'h6, 1'b0, 3'd4, 1'b1});
`endif

        bus.req_valid = 1'b0;
        bus.req_op    = NOP;
        bus.req_data  = 4'h0;
        bus.req_index = 3'd0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_command", int'(bus.command), 0);
        chk("rst_index", int'(bus.index), 0);
        chk("rst_doe", int'(bus.stk_doe), 0);
        chk("rst_dout", int'(bus.stk_dout), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_rsp_err", int'(bus.rsp_err), 0);
        chk("rst_depth", int'(bus.depth), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);

        foreach (tbl[i]) send(tbl[i]);

        // REQ_VALID held high: accepts only in IDLE, three cycles apart
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = NOP;
        bus.req_index = 3'd0;
        v = '{NOP, 4'h0, 3'd0, 4'h0, 1'b0, 3'd4, 1'b1};
        for (int c = 0; c < 7; c++) begin
            if (bus.req_ready) begin
                acc.push_back(c);
                sb.push_back(v);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        wait_sb_empty();
        chk("hold_accepts", acc.size(), 3);
        if (acc.size() == 3) begin
            chk("hold_gap0", acc[1] - acc[0], 3);
            chk("hold_gap1", acc[2] - acc[1], 3);
        end

        // Reset during the ISSUE cycle of a PUSH drops the op without a response
        while (!bus.req_ready) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = PUSH;
        bus.req_data  = 4'h9;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("inflight_cmd", int'(bus.command), int'(PUSH));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstf_command", int'(bus.command), 0);
        chk("rstf_ready", int'(bus.req_ready), 1);
        chk("rstf_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rstf_doe", int'(bus.stk_doe), 0);
        chk("rstf_depth", int'(bus.depth), 0);
        repeat (3) @(negedge clk);

        send('{PUSH, 4'h8, 3'd0, 4'h0, 1'b0, 3'd1, 1'b1});
        send('{GET,  4'h0, 3'd0, 4'h8, 1'b0, 3'd1, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
